dispatch_alloc_ctrl: RTL

DISPATCH_ALLOC_CTRL -- requirements
Module: dispatch_alloc_ctrl

---
 rtl/dispatch_alloc_ctrl_pkg.sv | 28 ++
 rtl/circ_ptr_cnt.sv | 34 +++
 rtl/dispatch_alloc_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dispatch_alloc_ctrl_pkg.sv
// Shared CPU sizing for the dispatch allocator: ROB and store-queue depths,
// pointer/counter widths, and small helpers.
package dispatch_alloc_ctrl_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int SQ_DEPTH  = 16;
   localparam int ROB_PW    = $clog2(ROB_DEPTH);
   localparam int SQ_PW     = $clog2(SQ_DEPTH);
   localparam int ROB_CW    = ROB_PW + 1;   // counter must reach DEPTH
   localparam int SQ_CW     = SQ_PW + 1;

   typedef logic [ROB_PW-1:0] rob_ptr_t;
   typedef logic [ROB_CW-1:0] rob_cnt_t;
   typedef logic [SQ_PW-1:0]  sq_ptr_t;
   typedef logic [SQ_CW-1:0]  sq_cnt_t;

   // per-group allocation demand
   typedef struct packed {
      logic [1:0] need;
      logic [1:0] st_need;
   } grp_need_t;

   // population count of two single-bit flags
   function automatic logic [1:0] cnt2(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/circ_ptr_cnt.sv
// Wrapping allocation pointer with occupancy counter. DEPTH must be a power
// of two so the pointer wraps naturally. load overrides add/sub (flush).
module circ_ptr_cnt #(
   parameter int DEPTH = 16,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] add,
   input  logic [AW-1:0] sub,
   input  logic          load,
   input  logic [PW-1:0] load_ptr,
   input  logic [CW-1:0] load_cnt,
   output logic [PW-1:0] ptr,
   output logic [CW-1:0] cnt
);

   // pointer advances by add; count tracks add minus sub; load rebases both
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
         cnt <= '0;
      end else if (load) begin
         ptr <= load_ptr;
         cnt <= load_cnt;
      end else begin
         ptr <= ptr + PW'(add);
         cnt <= cnt + CW'(add) - CW'(sub);
      end
   end

endmodule

// File: rtl/dispatch_alloc_ctrl.sv
// Dispatch allocation control: all-or-nothing dispatch of a two-slot group
// into the ROB and store queue, with flush recovery of both tails.
module dispatch_alloc_ctrl
   import dispatch_alloc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_valid,
   input  logic        inst1_valid,
   input  logic        inst2_valid,
   input  logic        inst1_is_store_op,
   input  logic        inst2_is_store_op,
   input  logic        iq_allowin,
   input  logic [1:0]  rob_commit_num,
   input  logic [1:0]  store_commit_num,
   input  logic        store_drain,
   input  logic        flush,
   output logic        ds_allowin,
   output logic        ds_to_is_valid,
   output logic        ds_to_rob_valid,
   output logic [3:0]  rob_tail_o,
   output logic [3:0]  store_head,
   output logic [3:0]  store_tail,
   output logic        rob_full,
   output logic        sq_full
);

   grp_need_t grp;
   rob_ptr_t  rob_tail;
   rob_cnt_t  rob_cnt;
   rob_cnt_t  rob_free;
   sq_ptr_t   sq_tail;
   sq_cnt_t   sq_cnt;
   sq_cnt_t   sq_free;
   sq_ptr_t   sq_head;
   sq_ptr_t   sq_commit;
   sq_cnt_t   sq_ccnt;     // committed but not yet drained
   logic      fire;
   logic [1:0] rob_add;
   logic [1:0] sq_add;
   rob_ptr_t  rob_head_nxt;
   sq_ptr_t   sq_tail_rec;
   sq_cnt_t   sq_cnt_rec;

   // group demand, admission and handshake
   always_comb begin
      grp.need    = cnt2(inst1_valid, inst2_valid);
      grp.st_need = cnt2(inst1_valid & inst1_is_store_op,
                         inst2_valid & inst2_is_store_op);
      rob_free    = rob_cnt_t'(ROB_DEPTH) - rob_cnt;
      sq_free     = sq_cnt_t'(SQ_DEPTH) - sq_cnt;
      fire        = ds_valid & iq_allowin & ~flush & ~reset &
                    (rob_free >= rob_cnt_t'(grp.need)) &
                    (sq_free  >= sq_cnt_t'(grp.st_need));
      rob_add     = fire ? grp.need    : 2'd0;
      sq_add      = fire ? grp.st_need : 2'd0;
   end

   // flush recovery targets: ROB tail back to post-commit head, store tail
   // back to the post-commit retire boundary keeping committed stores
   always_comb begin
      rob_head_nxt = rob_tail - rob_cnt[ROB_PW-1:0] + rob_ptr_t'(rob_commit_num);
      sq_tail_rec  = sq_commit + sq_ptr_t'(store_commit_num);
      sq_cnt_rec   = sq_ccnt + sq_cnt_t'(store_commit_num) - sq_cnt_t'(store_drain);
   end

   circ_ptr_cnt #(.DEPTH(ROB_DEPTH)) u_rob (
      .clk      (clk),
      .reset    (reset),
      .add      (rob_add),
      .sub      (rob_commit_num),
      .load     (flush),
      .load_ptr (rob_head_nxt),
      .load_cnt ('0),
      .ptr      (rob_tail),
      .cnt      (rob_cnt)
   );

   circ_ptr_cnt #(.DEPTH(SQ_DEPTH)) u_sq (
      .clk      (clk),
      .reset    (reset),
      .add      (sq_add),
      .sub      ({1'b0, store_drain}),
      .load     (flush),
      .load_ptr (sq_tail_rec),
      .load_cnt (sq_cnt_rec),
      .ptr      (sq_tail),
      .cnt      (sq_cnt)
   );

   // drain head and retire boundary keep moving through flushes
   always_ff @(posedge clk) begin
      if (reset) begin
         sq_head   <= '0;
         sq_commit <= '0;
         sq_ccnt   <= '0;
      end else begin
         sq_head   <= sq_head + sq_ptr_t'(store_drain);
         sq_commit <= sq_commit + sq_ptr_t'(store_commit_num);
         sq_ccnt   <= sq_ccnt + sq_cnt_t'(store_commit_num) - sq_cnt_t'(store_drain);
      end
   end

   // outputs
   always_comb begin
      ds_allowin      = fire | ~ds_valid;
      ds_to_is_valid  = fire;
      ds_to_rob_valid = fire;
      rob_tail_o      = rob_tail;
      store_head      = sq_head;
      store_tail      = sq_tail;
      rob_full        = rob_free < rob_cnt_t'(2);
      sq_full         = sq_free  < sq_cnt_t'(2);
   end

   // retiring more ROB entries than are allocated
   a_rob_commit: assert property (@(posedge clk) disable iff (reset)
      rob_cnt >= rob_cnt_t'(rob_commit_num));
   // retire boundary overtaking the allocation tail
   a_sq_commit: assert property (@(posedge clk) disable iff (reset)
      (sq_cnt - sq_ccnt) >= sq_cnt_t'(store_commit_num));
   // draining with no committed store available
   a_sq_drain: assert property (@(posedge clk) disable iff (reset)
      !(store_drain && sq_ccnt == '0));

endmodule
